// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, drives the next-address mux select,
// holds a pending branch across stalls and emits a one-cycle flush on every redirect.
module fetch_pc_sequencer #(
   parameter int PC_WIDTH = 8,
   parameter int PC_STEP  = 4,
   parameter int RESET_PC = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                Stall,
   input  logic                BranchTaken,
   input  logic [PC_WIDTH-1:0] BranchTarget,
   output logic [PC_WIDTH-1:0] PC,
   output logic                NextPCSel,
   output logic [PC_WIDTH-1:0] NextPC,
   output logic                FetchValid,
   output logic                Flush
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      STALL    = 2'd2,
      REDIRECT = 2'd3
   } state_t;

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic                r_flush;
   logic                r_pend_valid;
   logic [PC_WIDTH-1:0] r_pend_target;

   state_t              w_state_nxt;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic                w_flush_nxt;
   logic                w_pend_valid_nxt;
   logic [PC_WIDTH-1:0] w_pend_target_nxt;
   logic                w_sel;
   logic [PC_WIDTH-1:0] w_redir_addr;
   logic [PC_WIDTH-1:0] w_pc_inc;
   logic [PC_WIDTH-1:0] w_next_pc;

   // A live branch always beats a buffered one.
   assign w_redir_addr = BranchTaken ? BranchTarget : r_pend_target;
   assign w_pc_inc     = r_pc + PC_WIDTH'(PC_STEP);
   assign w_next_pc    = w_sel ? w_redir_addr : w_pc_inc;

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_flush_nxt       = 1'b0;
      w_pend_valid_nxt  = r_pend_valid;
      w_pend_target_nxt = r_pend_target;
      w_sel             = 1'b0;
      case (r_state)
         BOOT: begin
            w_state_nxt = Stall ? STALL : RUN;
         end
         RUN: begin
            if (BranchTaken) begin
               w_sel       = 1'b1;
               w_pc_nxt    = w_next_pc;
               w_flush_nxt = 1'b1;
               w_state_nxt = REDIRECT;
            end else if (Stall) begin
               w_state_nxt = STALL;
            end else begin
               w_pc_nxt    = w_next_pc;
            end
         end
         STALL: begin
            if (Stall) begin
               if (BranchTaken) begin
                  w_pend_target_nxt = BranchTarget;
                  w_pend_valid_nxt  = 1'b1;
               end
            end else if (BranchTaken || r_pend_valid) begin
               w_sel            = 1'b1;
               w_pc_nxt         = w_next_pc;
               w_pend_valid_nxt = 1'b0;
               w_flush_nxt      = 1'b1;
               w_state_nxt      = REDIRECT;
            end else begin
               // Held instruction is refetched from the unchanged PC.
               w_state_nxt = RUN;
            end
         end
         REDIRECT: begin
            if (BranchTaken) begin
               w_sel       = 1'b1;
               w_pc_nxt    = w_next_pc;
               w_flush_nxt = 1'b1;
            end else begin
               w_state_nxt = Stall ? STALL : RUN;
            end
         end
         default: begin
            w_state_nxt = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= BOOT;
         r_pc          <= PC_WIDTH'(RESET_PC);
         r_flush       <= 1'b0;
         r_pend_valid  <= 1'b0;
         r_pend_target <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_flush       <= w_flush_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_pend_target <= w_pend_target_nxt;
      end
   end

   assign PC         = r_pc;
   assign NextPCSel  = w_sel;
   assign NextPC     = w_next_pc;
   assign FetchValid = (r_state == RUN);
   assign Flush      = r_flush;

endmodule
